// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU mode constants, sequencer states and mode helpers
// Used by alu_arbiter_seq and its testbench; no ports.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;  // b - a
  localparam logic [2:0] ALU_CMP = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_NOP = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_legal_mode(input logic [2:0] mode);
    return (mode <= ALU_XOR);
  endfunction

  // Only the arithmetic modes produce a meaningful carry/borrow.
  function automatic logic writes_carry(input logic [2:0] mode);
    return (mode == ALU_ADD) || (mode == ALU_SUB) || (mode == ALU_CMP);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter
// Ports: clk, reset (sync, active-high), req[1:0] requests,
//        advance (a grant was consumed), grant (winning requester index).
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant
);

  logic ptr_q;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    grant = ptr_q;
    if (req == 2'b01) grant = 1'b0;
    if (req == 2'b10) grant = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else if (advance) begin
      ptr_q <= ~grant;
    end
  end

endmodule

// File: rtl/alu_arbiter_seq.sv
// rtl/alu_arbiter_seq.sv - round-robin sequencer sharing one combinational ALU
// Ports: clk, reset (sync, active-high);
//        req_valid/req_ready[1:0], req_mode0/1, req_a0/1, req_b0/1 request side;
//        rsp_valid/rsp_ready, rsp_id, rsp_data, rsp_zero, rsp_carry, rsp_err response side;
//        flags_clr, flag_zero_q, flag_carry_q architectural flags;
//        alu_in1, alu_in2, alu_mode to the ALU; alu_out, alu_zero, alu_carry from it.
module alu_arbiter_seq
  import alu_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2:0]        req_mode0,
  input  logic [2:0]        req_mode1,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_b1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_carry,
  output logic              rsp_err,
  input  logic              flags_clr,
  output logic              flag_zero_q,
  output logic              flag_carry_q,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [2:0]        alu_mode,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  input  logic              alu_carry
);

  localparam logic [2:0] CNT_INIT = 3'(SETTLE_CYCLES - 1);

  state_t            state_q, next_state;
  logic              grant;
  logic              accept;
  logic              capture;
  logic              primed_q;
  logic [2:0]        cnt_q;
  logic              id_q;
  logic [2:0]        mode_q;
  logic [2:0]        sel_mode;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic              new_carry;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  assign sel_mode  = grant ? req_mode1 : req_mode0;
  assign sel_a     = grant ? req_a1 : req_a0;
  assign sel_b     = grant ? req_b1 : req_b0;
  assign accept    = (state_q == IDLE) && (|req_valid);
  // The first EXEC cycle lets the freshly registered operands ripple through
  // the ALU; the settle counter only starts after that.
  assign capture   = (state_q == EXEC) && primed_q && (cnt_q == 3'd0);
  assign new_carry = writes_carry(mode_q) ? alu_carry : flag_carry_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= next_state;
  end

  always_comb begin
    next_state = state_q;
    req_ready  = 2'b00;
    rsp_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready[grant] = 1'b1;
          next_state = is_legal_mode(sel_mode) ? EXEC : RESP;
        end
      end
      EXEC: begin
        if (capture) next_state = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      primed_q     <= 1'b0;
      id_q         <= 1'b0;
      mode_q       <= ALU_NOP;
      rsp_id       <= 1'b0;
      rsp_data     <= '0;
      rsp_zero     <= 1'b0;
      rsp_carry    <= 1'b0;
      rsp_err      <= 1'b0;
      flag_zero_q  <= 1'b0;
      flag_carry_q <= 1'b0;
      alu_in1      <= '0;
      alu_in2      <= '0;
      alu_mode     <= ALU_NOP;
    end else begin
      if (accept) begin
        id_q   <= grant;
        mode_q <= sel_mode;
        if (is_legal_mode(sel_mode)) begin
          alu_in1  <= sel_a;
          alu_in2  <= sel_b;
          alu_mode <= sel_mode;
          cnt_q    <= CNT_INIT;
          primed_q <= 1'b0;
        end else begin
          // Illegal ops never touch the ALU; answer straight away with current flags.
          rsp_id    <= grant;
          rsp_data  <= '0;
          rsp_err   <= 1'b1;
          rsp_zero  <= flag_zero_q;
          rsp_carry <= flag_carry_q;
        end
      end
      if (state_q == EXEC) begin
        if (!primed_q)           primed_q <= 1'b1;
        else if (cnt_q != 3'd0)  cnt_q    <= cnt_q - 3'd1;
      end
      if (capture) begin
        rsp_id       <= id_q;
        // Compare answers with operand b, which alu_in2 still holds.
        rsp_data     <= (mode_q == ALU_CMP) ? alu_in2 : alu_out;
        rsp_err      <= 1'b0;
        rsp_zero     <= alu_zero;
        rsp_carry    <= new_carry;
        flag_zero_q  <= alu_zero;
        flag_carry_q <= new_carry;
        alu_mode     <= ALU_NOP;
      end
      // Clear wins over a same-edge capture; response registers are untouched.
      if (flags_clr) begin
        flag_zero_q  <= 1'b0;
        flag_carry_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// tb/tb_alu_arbiter_seq.sv - self-checking bench for alu_arbiter_seq
module tb_alu_arbiter_seq;

  localparam int W = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid, req_ready;
  logic [2:0]   req_mode0, req_mode1;
  logic [W-1:0] req_a0, req_a1, req_b0, req_b1;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0] rsp_data;
  logic         rsp_zero, rsp_carry, rsp_err;
  logic         flags_clr, flag_zero_q, flag_carry_q;
  logic [W-1:0] alu_in1, alu_in2, alu_out;
  logic [2:0]   alu_mode;
  logic         alu_zero, alu_carry;

  always #5 clk = ~clk;

  alu_arbiter_seq #(.DATA_W(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mode0(req_mode0), .req_mode1(req_mode1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .flags_clr(flags_clr), .flag_zero_q(flag_zero_q), .flag_carry_q(flag_carry_q),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_mode(alu_mode),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry)
  );

  // Stand-in for the shared combinational ALU.
  function automatic logic [9:0] alu_fn(input logic [2:0] m, input logic [7:0] x, input logic [7:0] y);
    logic [8:0] s;
    logic z, c;
    case (m)
      3'd0:    s = {1'b0, x} + {1'b0, y};
      3'd1:    s = {1'b0, y} - {1'b0, x};
      3'd2:    s = {1'b0, y} - {1'b0, x};
      3'd3:    s = {1'b0, x & y};
      3'd4:    s = {1'b0, x | y};
      3'd5:    s = {1'b0, x ^ y};
      default: s = 9'd0;
    endcase
    z = (s[7:0] == 8'd0);
    c = s[8];
    if (m == 3'd2) begin
      z = (x == y);
      c = (x > y);
    end
    return {z, c, s[7:0]};
  endfunction

  always_comb {alu_zero, alu_carry, alu_out} = alu_fn(alu_mode, alu_in1, alu_in2);

  // Transaction-level reference: who wins, how long until the answer, what the answer is.
  int         m_ptr, m_busy;
  bit         m_pend, m_acc;
  logic       m_id, m_rid, m_z, m_c, m_err, m_fz, m_fc;
  logic [2:0] m_mode, m_amode;
  logic [7:0] m_a, m_b, m_data, m_in1, m_in2;
  int         vectors = 0;
  int         miscompares = 0;

  function automatic int pick();
    if (req_valid == 2'b11) return m_ptr;
    return req_valid[1] ? 1 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_capture();
    int ia, ib, r;
    ia = m_a;
    ib = m_b;
    m_rid = m_id;
    m_err = 1'b0;
    case (m_mode)
      3'd0: begin r = ia + ib; m_data = 8'(r % 256); m_c = (r > 255); end
      3'd1: begin r = ib - ia; m_data = 8'((r + 256) % 256); m_c = (ib < ia); end
      3'd2: begin m_data = m_b; m_c = (ia > ib); end
      3'd3: begin m_data = m_a & m_b; m_c = m_fc; end
      3'd4: begin m_data = m_a | m_b; m_c = m_fc; end
      default: begin m_data = m_a ^ m_b; m_c = m_fc; end
    endcase
    m_z = (m_mode == 3'd2) ? (ia == ib) : (m_data == 8'd0);
    m_fz = m_z;
    m_fc = m_c;
    m_amode = 3'b111;
  endtask

  task automatic model_step();
    int w;
    m_acc = 1'b0;
    if (reset) begin
      m_ptr = 0; m_busy = 0; m_pend = 1'b0;
      m_fz = 1'b0; m_fc = 1'b0; m_amode = 3'b111; m_in1 = 8'd0; m_in2 = 8'd0;
      return;
    end
    if (m_busy == 1) begin
      model_capture();
      m_busy = 0;
      m_pend = 1'b1;
    end else if (m_busy > 1) begin
      m_busy--;
    end else if (m_pend) begin
      if (rsp_ready) m_pend = 1'b0;
    end else if (req_valid != 2'b00) begin
      w = pick();
      m_acc = 1'b1;
      m_ptr = 1 - w;
      m_id = (w == 1);
      m_mode = (w == 1) ? req_mode1 : req_mode0;
      m_a = (w == 1) ? req_a1 : req_a0;
      m_b = (w == 1) ? req_b1 : req_b0;
      if (m_mode > 3'd5) begin
        m_pend = 1'b1; m_rid = m_id; m_data = 8'd0; m_err = 1'b1; m_z = m_fz; m_c = m_fc;
      end else begin
        m_busy = S + 1; m_in1 = m_a; m_in2 = m_b; m_amode = m_mode;
      end
    end
    if (flags_clr) begin
      m_fz = 1'b0;
      m_fc = 1'b0;
    end
  endtask

  task automatic compare();
    logic [1:0] exp_rdy;
    exp_rdy = 2'b00;
    if (!m_pend && m_busy == 0 && req_valid != 2'b00) exp_rdy = (pick() == 1) ? 2'b10 : 2'b01;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_pend));
    if (m_pend) begin
      chk("rsp_id", 32'(rsp_id), 32'(m_rid));
      chk("rsp_data", 32'(rsp_data), 32'(m_data));
      chk("rsp_zero", 32'(rsp_zero), 32'(m_z));
      chk("rsp_carry", 32'(rsp_carry), 32'(m_c));
      chk("rsp_err", 32'(rsp_err), 32'(m_err));
    end
    chk("flag_zero_q", 32'(flag_zero_q), 32'(m_fz));
    chk("flag_carry_q", 32'(flag_carry_q), 32'(m_fc));
    chk("alu_mode", 32'(alu_mode), 32'(m_amode));
    chk("alu_in1", 32'(alu_in1), 32'(m_in1));
    chk("alu_in2", 32'(alu_in2), 32'(m_in2));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic run_op(input int id, input logic [2:0] mode, input logic [7:0] a,
                        input logic [7:0] b, output int lat);
    int n;
    if (id == 0) begin req_mode0 = mode; req_a0 = a; req_b0 = b; req_valid = 2'b01; end
    else         begin req_mode1 = mode; req_a1 = a; req_b1 = b; req_valid = 2'b10; end
    n = 0;
    do begin tick(); n++; end while (!m_acc && n < 20);
    if (!m_acc) chk("accept_timeout", 32'd0, 32'd1);
    req_valid = 2'b00;
    lat = 0;
    while (!rsp_valid && lat < 30) begin tick(); lat++; end
    if (!rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat, n;
    logic [7:0] d0;
    logic ids[$];
    reset = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1; flags_clr = 1'b0;
    req_mode0 = 3'd0; req_mode1 = 3'd0;
    req_a0 = 8'd0; req_a1 = 8'd0; req_b0 = 8'd0; req_b1 = 8'd0;
    repeat (3) tick();
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_alu_mode", 32'(alu_mode), 32'h7);
    chk("reset_flags", 32'({flag_zero_q, flag_carry_q}), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    reset = 1'b0;
    tick();

    // Both requesters held: answers must alternate 0,1,0,1.
    req_mode0 = 3'd0; req_a0 = 8'h11; req_b0 = 8'h22;
    req_mode1 = 3'd5; req_a1 = 8'h0F; req_b1 = 8'hF0;
    req_valid = 2'b11;
    n = 0;
    while (ids.size() < 4 && n < 60) begin
      tick(); n++;
      if (rsp_valid && rsp_ready) ids.push_back(rsp_id);
    end
    req_valid = 2'b00;
    chk("rr_count", 32'(ids.size()), 32'd4);
    for (int i = 0; i < ids.size(); i++) chk("rr_order", 32'(ids[i]), 32'(i % 2));
    tick(); tick();

    reset = 1'b1; tick(); reset = 1'b0; tick();
    run_op(0, 3'd0, 8'hF0, 8'h20, lat);
    chk("add_latency", 32'(lat), 32'(S + 1));
    chk("add_id", 32'(rsp_id), 32'd0);
    chk("add_data", 32'(rsp_data), 32'h10);
    chk("add_carry", 32'(rsp_carry), 32'd1);
    chk("add_zero", 32'(rsp_zero), 32'd0);
    chk("add_flag_carry", 32'(flag_carry_q), 32'd1);
    tick();

    run_op(0, 3'd5, 8'h55, 8'h55, lat);
    chk("xor_data", 32'(rsp_data), 32'd0);
    chk("xor_zero", 32'(rsp_zero), 32'd1);
    chk("xor_carry_kept", 32'(rsp_carry), 32'd1);
    tick();
    run_op(1, 3'd2, 8'h07, 8'h03, lat);
    chk("cmp_data", 32'(rsp_data), 32'h03);
    chk("cmp_zero", 32'(rsp_zero), 32'd0);
    chk("cmp_carry", 32'(rsp_carry), 32'd1);
    tick();

    run_op(1, 3'd6, 8'h12, 8'h34, lat);
    chk("illegal_latency", 32'(lat), 32'd0);
    chk("illegal_err", 32'(rsp_err), 32'd1);
    chk("illegal_data", 32'(rsp_data), 32'd0);
    chk("illegal_flags", 32'({rsp_zero, rsp_carry}), 32'b01);
    chk("illegal_alu_mode", 32'(alu_mode), 32'h7);
    tick();

    // Backpressure with both requesters still asking.
    rsp_ready = 1'b0;
    run_op(0, 3'd0, 8'hF0, 8'h20, lat);
    d0 = rsp_data;
    req_valid = 2'b11;
    repeat (5) begin
      tick();
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", 32'(rsp_data), 32'(d0));
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_release_idle", 32'(req_ready != 2'b00), 32'd1);
    req_valid = 2'b00;
    tick();

    // Reset in the middle of a subtract.
    req_mode0 = 3'd1; req_a0 = 8'h02; req_b0 = 8'h01; req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_exec_valid", 32'(rsp_valid), 32'd0);
    chk("rst_exec_flags", 32'({flag_zero_q, flag_carry_q}), 32'd0);
    chk("rst_exec_alu_mode", 32'(alu_mode), 32'h7);
    repeat (6) begin tick(); chk("rst_no_rsp", 32'(rsp_valid), 32'd0); end

    // Flag clear on the capture edge.
    req_mode0 = 3'd1; req_a0 = 8'h02; req_b0 = 8'h01; req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    repeat (S) tick();
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0;
    chk("clr_valid", 32'(rsp_valid), 32'd1);
    chk("clr_data", 32'(rsp_data), 32'hFF);
    chk("clr_rsp_carry", 32'(rsp_carry), 32'd1);
    chk("clr_flags", 32'({flag_zero_q, flag_carry_q}), 32'd0);
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      req_valid = 2'($urandom_range(0, 3));
      req_mode0 = 3'($urandom_range(0, 7));
      req_mode1 = 3'($urandom_range(0, 7));
      req_a0 = 8'($urandom); req_b0 = 8'($urandom);
      req_a1 = 8'($urandom); req_b1 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) req_b0 = req_a0;
      rsp_ready = ($urandom_range(0, 2) != 0);
      flags_clr = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0; flags_clr = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
